// File: rtl/tx_filter_ctrl_pkg.sv
// Shared definitions for the transmit pulse-shaping controller:
// controller state encoding, symbol width, default idle symbol and
// underflow counter width/saturation helper.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_e;

  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 2'b00;
  localparam int UF_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UF_CNT_W-1:0] sat_inc(input logic [UF_CNT_W-1:0] v);
    return (v == {UF_CNT_W{1'b1}}) ? v : v + UF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tx_filter_ctrl_if.sv
// Upstream symbol handshake: the source presents a symbol with a valid
// flag, the controller signals when it takes it.
interface tx_filter_ctrl_if;
  import tx_ctrl_pkg::*;

  logic [SYM_W-1:0] i_sym;
  logic             i_sym_valid;
  logic             o_sym_ready;

  modport master (output i_sym, output i_sym_valid, input o_sym_ready);
  modport slave  (input i_sym, input i_sym_valid, output o_sym_ready);

endinterface

// File: rtl/tx_filter_ctrl_phase.sv
// Oversampling phase counter: counts 0..N_OS-1 while enabled, with a
// combinational strobe on the last phase of each symbol period.
module os_phase_counter #(
  parameter int N_OS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_clr,
  output logic [$clog2(N_OS)-1:0] o_phase,
  output logic                    o_wrap
);

  localparam int PH_W = $clog2(N_OS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_OS - 1);

  logic [PH_W-1:0] r_phase;

  assign o_phase = r_phase;
  assign o_wrap  = i_en && (r_phase == PH_LAST);

  // Advance the phase each enabled clock; clear has priority so the
  // controller can return to phase 0 when it drops back to idle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    r_phase <= '0;
    else if (i_clr) r_phase <= '0;
    else if (i_en)  r_phase <= o_wrap ? '0 : r_phase + 1'b1;
  end

endmodule

// File: rtl/tx_filter_ctrl.sv
// Transmit FIR controller: fetches one symbol per oversampling period,
// primes the delay line, runs, and drains with idle symbols on stop.
module tx_filter_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int               N_OS     = 4,
  parameter int               LFILT    = 6,
  parameter logic [SYM_W-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_stop,
  tx_filter_ctrl_if.slave         sym_if,
  output logic [SYM_W-1:0]        o_ak,
  output logic                    o_shift_en,
  output logic [$clog2(N_OS)-1:0] o_phase,
  output logic                    o_out_valid,
  output logic                    o_busy,
  output logic [UF_CNT_W-1:0]     o_underflow_cnt
);

  localparam int CNT_W = $clog2(LFILT + 1);
  localparam logic [CNT_W-1:0] PRIME_SHIFTS = CNT_W'(LFILT);
  localparam logic [CNT_W-1:0] DRAIN_SHIFTS = CNT_W'(LFILT - 1);

  tx_state_e             r_state;
  logic [SYM_W-1:0]      r_ak;
  logic                  r_shift_en;
  logic                  r_out_valid;
  logic                  r_stop_pending;
  logic [CNT_W-1:0]      r_shift_cnt;   // PRIME: symbols loaded, DRAIN: idle shifts issued
  logic [UF_CNT_W-1:0]   r_uf_cnt;

  logic [$clog2(N_OS)-1:0] w_phase;
  logic w_wrap, w_active, w_loading, w_ph0, w_stop_req, w_ready;
  logic w_abort, w_drain_done, w_go_idle;

  assign w_active   = (r_state != ST_IDLE);
  assign w_loading  = (r_state == ST_PRIME) || (r_state == ST_RUN);
  assign w_ph0      = (w_phase == '0);
  assign w_stop_req = w_loading && (r_stop_pending || i_stop);
  // A stop arriving on the fetch cycle itself suppresses that fetch.
  assign w_ready    = w_loading && w_ph0 && !w_stop_req;

  assign w_abort      = (r_state == ST_PRIME) && ((w_ph0 && i_stop) || (w_wrap && w_stop_req));
  assign w_drain_done = (r_state == ST_DRAIN) && w_wrap && (r_shift_cnt == DRAIN_SHIFTS);
  assign w_go_idle    = w_abort || w_drain_done;

  os_phase_counter #(.N_OS(N_OS)) u_phase (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_active),
    .i_clr   (w_go_idle),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  assign sym_if.o_sym_ready = w_ready;
  assign o_ak               = r_ak;
  assign o_shift_en         = r_shift_en;
  assign o_phase            = w_phase;
  assign o_out_valid        = r_out_valid;
  assign o_busy             = w_active;
  assign o_underflow_cnt    = r_uf_cnt;

  // Controller FSM with registered symbol, shift strobe, valid and counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_ak           <= IDLE_SYM;
      r_shift_en     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_stop_pending <= 1'b0;
      r_shift_cnt    <= '0;
      r_uf_cnt       <= '0;
    end else begin
      r_shift_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_state        <= ST_PRIME;
            r_shift_cnt    <= '0;
            r_stop_pending <= 1'b0;
            r_uf_cnt       <= '0;
          end
        end
        ST_PRIME, ST_RUN: begin
          if (i_stop && !w_ph0) r_stop_pending <= 1'b1;
          if (w_ready) begin
            r_ak       <= sym_if.i_sym_valid ? sym_if.i_sym : IDLE_SYM;
            r_shift_en <= 1'b1;
            if (r_state == ST_PRIME)      r_shift_cnt <= r_shift_cnt + 1'b1;
            else if (!sym_if.i_sym_valid) r_uf_cnt    <= sat_inc(r_uf_cnt);
          end
          if (w_ph0 && i_stop) begin
            // Stop on the fetch cycle: this boundary is the transition.
            r_stop_pending <= 1'b0;
            if (r_state == ST_PRIME) begin
              r_state <= ST_IDLE;
            end else begin
              r_state     <= ST_DRAIN;
              r_ak        <= IDLE_SYM;
              r_shift_en  <= 1'b1;
              r_shift_cnt <= CNT_W'(1);
            end
          end else if (w_wrap) begin
            if (w_stop_req) begin
              r_stop_pending <= 1'b0;
              r_shift_cnt    <= '0;
              r_state        <= (r_state == ST_PRIME) ? ST_IDLE : ST_DRAIN;
            end else if ((r_state == ST_PRIME) && (r_shift_cnt == PRIME_SHIFTS)) begin
              r_state     <= ST_RUN;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_ph0 && (r_shift_cnt != DRAIN_SHIFTS)) begin
            r_ak        <= IDLE_SYM;
            r_shift_en  <= 1'b1;
            r_shift_cnt <= r_shift_cnt + 1'b1;
          end
          if (w_drain_done) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_filter_ctrl.sv
// Bench for tx_filter_ctrl: randomized transactions, expected shifts queued
// by a transaction-level model, checked by an independent monitor.
module tb_tx_filter_ctrl;
  import tx_ctrl_pkg::*;

  localparam int N = 4;
  localparam int L = 6;
  localparam logic [1:0] IDL = 2'b00;

  logic       i_clk = 1'b0;
  logic       i_reset, i_start, i_stop;
  logic [1:0] o_ak;
  logic       o_shift_en;
  logic [1:0] o_phase;
  logic       o_out_valid, o_busy;
  logic [15:0] o_underflow_cnt;

  tx_filter_ctrl_if u_if ();

  tx_filter_ctrl #(.N_OS(N), .LFILT(L), .IDLE_SYM(IDL)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .sym_if          (u_if),
    .o_ak            (o_ak),
    .o_shift_en      (o_shift_en),
    .o_phase         (o_phase),
    .o_out_valid     (o_out_valid),
    .o_busy          (o_busy),
    .o_underflow_cnt (o_underflow_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [1:0] ak; } shift_t;
  shift_t exq[$];

  // Transaction model: windows of expected activity for the current run.
  int act = 0, c0 = 0, busy_end = 0, rdy_end = 0, ov_lo = 0, ov_hi = 0;
  int n_cmp = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Monitor: per-cycle control outputs against the windows, shifts against the queue.
  always @(negedge i_clk) begin
    int t, rel, ep;
    bit eb, er, eo;
    shift_t e;
    t   = cyc;
    rel = t - c0 - 1;
    eb  = (act != 0) && (t >= c0 + 1) && (t < busy_end);
    er  = (act != 0) && (t >= c0 + 1) && (t < rdy_end) && (rel % N == 0);
    eo  = (act != 0) && (t >= ov_lo) && (t < ov_hi);
    ep  = eb ? (rel % N) : 0;
    check("busy", o_busy, eb);
    check("sym_ready", u_if.o_sym_ready, er);
    check("out_valid", o_out_valid, eo);
    check("phase", o_phase, ep);
    if (eb && (t < c0 + 1 + L * N)) check("uf_cleared", o_underflow_cnt, 0);
    while (exq.size() > 0 && exq[0].cyc < t) begin
      check("shift_missing_at", t, exq[0].cyc);
      void'(exq.pop_front());
    end
    if (o_shift_en === 1'b1) begin
      if (exq.size() == 0) begin
        check("shift_unexpected", 1, 0);
      end else begin
        e = exq.pop_front();
        check("shift_cycle", t, e.cyc);
        check("shift_ak", o_ak, e.ak);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      i_start = 1'b0; i_stop = 1'b0;
      u_if.i_sym = 2'($urandom_range(0, 3));
      u_if.i_sym_valid = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
    end
  endtask

  // One transmission: start at the current cycle, stop ts_off cycles later,
  // optionally hit with an asynchronous reset rst_off cycles after start.
  task automatic run_txn(input int ts_off, input int drop_pct, input int rst_off);
    int ts, b, kstop, run_start, n_uf, t, t_end, k, rel;
    bit rst_done;
    logic [1:0] syms [64];
    bit vlds [64];
    shift_t e;
    t = cyc; c0 = t;
    run_start = c0 + 1 + L * N;
    ts = c0 + ts_off;
    b = c0 + 1 + ((ts - c0 - 1 + N - 1) / N) * N;   // first fetch cycle at/after the stop
    kstop = (b - c0 - 1) / N;                       // symbols fetched before it
    rdy_end = b; ov_lo = 0; ov_hi = 0; n_uf = 0;
    if (ts < run_start) begin
      busy_end = (ts == b) ? b + 1 : b;
    end else begin
      busy_end = b + (L - 1) * N;
      ov_lo = run_start; ov_hi = busy_end;
    end
    for (int i = 0; i < kstop; i++) begin
      syms[i] = 2'($urandom_range(0, 3));
      vlds[i] = ($urandom_range(0, 99) >= drop_pct);
      e.cyc = c0 + 2 + i * N;
      e.ak  = vlds[i] ? syms[i] : IDL;
      exq.push_back(e);
      if (i >= L && !vlds[i]) n_uf++;
    end
    if (ts >= run_start)
      for (int j = 0; j < L - 1; j++) begin
        e.cyc = b + 1 + j * N; e.ak = IDL; exq.push_back(e);
      end
    act = 1; rst_done = 1'b0;
    t_end = busy_end + 2;
    while (t <= t_end) begin
      rel = t - c0 - 1;
      k = (rel >= 0) ? rel / N : 0;
      if (rst_off > 0 && t == c0 + rst_off) begin
        i_start = 1'b0; i_stop = 1'b0;
        #2 i_reset = 1'b1;
        act = 0; exq.delete();
        #1;
        check("rst_ak", o_ak, IDL);
        check("rst_shift_en", o_shift_en, 0);
        check("rst_ready", u_if.o_sym_ready, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_phase", o_phase, 0);
        check("rst_uf", o_underflow_cnt, 0);
        rst_done = 1'b1; t_end = t + 20;
      end else begin
        i_reset = 1'b0;
        i_start = (t == c0) || (!rst_done && t > c0 && t < busy_end - 1 && $urandom_range(0, 7) == 0);
        i_stop  = !rst_done && ((t == ts) ||
                  (ts >= run_start && t > ts && t < busy_end - 1 && $urandom_range(0, 5) == 0));
      end
      if (rel >= 0 && rel % N == 0 && k < kstop) begin
        u_if.i_sym = syms[k]; u_if.i_sym_valid = vlds[k];
      end else begin
        u_if.i_sym = 2'($urandom_range(0, 3));
        u_if.i_sym_valid = 1'($urandom_range(0, 1));
      end
      @(posedge i_clk); #1;
      t++;
    end
    i_reset = 1'b0;
    if (rst_done) check("uf_after_reset", o_underflow_cnt, 0);
    else          check("uf_count", o_underflow_cnt, n_uf);
    act = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    u_if.i_sym = 2'b11; u_if.i_sym_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("init_ak", o_ak, IDL);
    check("init_shift_en", o_shift_en, 0);
    check("init_ready", u_if.o_sym_ready, 0);
    check("init_busy", o_busy, 0);
    check("init_uf", o_underflow_cnt, 0);
    i_reset = 1'b0;
    idle_cycles(3);
    // Constant valid, stop in RUN at phase 2.
    run_txn(1 + L * N + 4 + 2, 0, 0);
    idle_cycles(3);
    // Dropped symbols in RUN, stop coincident with a fetch cycle.
    run_txn(1 + (L + 5) * N, 35, 0);
    idle_cycles(2);
    // Aborts during PRIME: on a fetch cycle, mid-symbol, and on the last prime symbol.
    run_txn(1 + 2 * N, 0, 0);
    idle_cycles(2);
    run_txn(1 + 3 * N + 1, 0, 0);
    idle_cycles(2);
    run_txn(1 + (L - 1) * N + 3, 0, 0);
    idle_cycles(2);
    // Start together with stop while idle.
    i_start = 1'b1; i_stop = 1'b1;
    @(posedge i_clk); #1;
    idle_cycles(6);
    // Asynchronous reset in the middle of RUN.
    run_txn(1 + (L + 8) * N + 1, 25, 1 + (L + 3) * N + 2);
    idle_cycles(2);
    repeat (8) begin
      run_txn(1 + $urandom_range(0, (L + 10) * N), $urandom_range(0, 50), 0);
      idle_cycles($urandom_range(0, 3));
    end
    check("queue_empty", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
